// File: rtl/stream_patch_mc.sv
// -----------------------------------------------------------------------------
// stream_patch_mc
//
// Slides a PATCH_HEIGHT x PATCH_WIDTH window over a continuous raster stream of
// CHANNELS packed samples. Border handling is chosen at run time (none, zero,
// replicate, mirror) and is latched once per frame, at the pixel whose center
// tap is (0,0). The window is built from PATCH_HEIGHT-1 line delays feeding a
// shift-register window. The center coordinates are derived arithmetically
// from the input counters.
//
// Ports
//   clock      in   system clock
//   n_rst      in   asynchronous active-low reset
//   in_pixel   in   input sample, channel c at [c*BIT_WIDTH +: BIT_WIDTH]
//   in_vcnt    in   input line counter (continuous raster, wraps at FRAME_HEIGHT)
//   in_hcnt    in   input pixel counter (wraps at FRAME_WIDTH)
//   pad_mode   in   0 none, 1 zero, 2 replicate, 3 mirror
//   out_patch  out  border-handled window, same channel packing as in_pixel
//   out_vcnt   out  line of the center tap
//   out_hcnt   out  pixel of the center tap
//   out_valid  out  center tap inside the image and warm-up complete
// -----------------------------------------------------------------------------
module stream_patch_mc #(
    parameter int CHANNELS     = 1,
    parameter int BIT_WIDTH    = 8,
    parameter int IMAGE_HEIGHT = 480,
    parameter int IMAGE_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 525,
    parameter int FRAME_WIDTH  = 800,
    parameter int PATCH_HEIGHT = 3,
    parameter int PATCH_WIDTH  = 3,
    parameter int CENTER_V     = PATCH_HEIGHT / 2,
    parameter int CENTER_H     = PATCH_WIDTH / 2
) (
    input  logic                                   clock,
    input  logic                                   n_rst,
    input  logic [CHANNELS*BIT_WIDTH-1:0]          in_pixel,
    input  logic [$clog2(FRAME_HEIGHT)-1:0]        in_vcnt,
    input  logic [$clog2(FRAME_WIDTH)-1:0]         in_hcnt,
    input  logic [1:0]                             pad_mode,
    output logic [0:PATCH_HEIGHT-1][0:PATCH_WIDTH-1][CHANNELS*BIT_WIDTH-1:0] out_patch,
    output logic [$clog2(FRAME_HEIGHT)-1:0]        out_vcnt,
    output logic [$clog2(FRAME_WIDTH)-1:0]         out_hcnt,
    output logic                                   out_valid
);

    localparam int PIX_W   = CHANNELS * BIT_WIDTH;
    localparam int VW      = $clog2(FRAME_HEIGHT);
    localparam int HW      = $clog2(FRAME_WIDTH);
    localparam int DLY_D   = FRAME_WIDTH - PATCH_WIDTH;
    localparam int LATENCY = (PATCH_HEIGHT - 1 - CENTER_V) * FRAME_WIDTH
                           + (PATCH_WIDTH - 1 - CENTER_H) + 2;
    localparam int WU_W    = $clog2(LATENCY + 1);

    // The window center lags the input by LATENCY-1 samples; split that lag
    // into whole lines (LQ) and a remaining pixel offset (LR).
    localparam int LAG     = LATENCY - 1;
    localparam int LQ      = (LAG / FRAME_WIDTH) % FRAME_HEIGHT;
    localparam int LR      = LAG % FRAME_WIDTH;

    localparam int MAX_V   = (CENTER_V > PATCH_HEIGHT - 1 - CENTER_V) ?
                             CENTER_V : PATCH_HEIGHT - 1 - CENTER_V;
    localparam int MAX_H   = (CENTER_H > PATCH_WIDTH - 1 - CENTER_H) ?
                             CENTER_H : PATCH_WIDTH - 1 - CENTER_H;

    // Mirror padding must never reflect past the opposite image edge.
    if (IMAGE_HEIGHT <= MAX_V || IMAGE_WIDTH <= MAX_H) begin : g_mirror_chk
        $error("stream_patch_mc: image too small for mirror padding of this patch");
    end

    // Window tap index that supplies tap k, given the center position ctr,
    // center offset c and image extent n. Substitution only ever redirects to
    // another tap of the same window.
    function automatic int tap_sel(input int ctr, input int k, input int c,
                                   input int n, input logic [1:0] mode);
        int r;
        r       = ctr + k - c;
        tap_sel = k;
        if (mode == 2'd2) begin
            if (r < 0)       tap_sel = k - r;
            else if (r >= n) tap_sel = k - (r - (n - 1));
        end else if (mode == 2'd3) begin
            if (r < 0)       tap_sel = k - 2 * r;
            else if (r >= n) tap_sel = k - 2 * (r - (n - 1));
        end
    endfunction

    function automatic logic tap_out(input int ctr, input int k, input int c,
                                     input int n);
        int r;
        r       = ctr + k - c;
        tap_out = (r < 0) || (r >= n);
    endfunction

    logic [PIX_W-1:0] win_q  [PATCH_HEIGHT][PATCH_WIDTH];
    logic [PIX_W-1:0] row_in [PATCH_HEIGHT];

    logic [0:PATCH_HEIGHT-1][0:PATCH_WIDTH-1][PIX_W-1:0] out_patch_q, out_patch_d;
    logic [VW-1:0]   out_vcnt_q, out_vcnt_d;
    logic [HW-1:0]   out_hcnt_q, out_hcnt_d;
    logic            out_valid_q, out_valid_d;
    logic [WU_W-1:0] wu_q, wu_d;
    logic [1:0]      mode_q, mode_d;

    int   ctr_v, ctr_h, vsub;
    logic in_img, at_origin, wu_done;
    logic [1:0] mode_eff;
    int   rsel [PATCH_HEIGHT];
    int   csel [PATCH_WIDTH];
    logic rzero [PATCH_HEIGHT];
    logic czero [PATCH_WIDTH];

    // Line delays: row v+1 column 0 feeds row v column PATCH_WIDTH-1 one line later.
    assign row_in[PATCH_HEIGHT-1] = in_pixel;

    for (genvar gv = 0; gv < PATCH_HEIGHT - 1; gv++) begin : g_line
        logic [PIX_W-1:0] dly_q [DLY_D];

        always_ff @(posedge clock or negedge n_rst) begin
            if (!n_rst) begin
                for (int i = 0; i < DLY_D; i++) dly_q[i] <= '0;
            end else begin
                dly_q[0] <= win_q[gv+1][0];
                for (int i = 1; i < DLY_D; i++) dly_q[i] <= dly_q[i-1];
            end
        end

        assign row_in[gv] = dly_q[DLY_D-1];
    end

    // Window stage: newest sample enters at the right, columns shift left.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            for (int v = 0; v < PATCH_HEIGHT; v++)
                for (int h = 0; h < PATCH_WIDTH; h++)
                    win_q[v][h] <= '0;
        end else begin
            for (int v = 0; v < PATCH_HEIGHT; v++) begin
                for (int h = 0; h < PATCH_WIDTH - 1; h++)
                    win_q[v][h] <= win_q[v][h+1];
                win_q[v][PATCH_WIDTH-1] <= row_in[v];
            end
        end
    end

    // Center coordinate: input position minus the lag, borrowing across lines
    // and wrapping at the frame boundary.
    always_comb begin
        ctr_h = 0;
        ctr_v = 0;
        vsub  = LQ;
        if (int'(in_hcnt) >= LR) begin
            ctr_h = int'(in_hcnt) - LR;
            vsub  = LQ;
        end else begin
            ctr_h = int'(in_hcnt) + FRAME_WIDTH - LR;
            vsub  = LQ + 1;
        end
        if (int'(in_vcnt) >= vsub) ctr_v = int'(in_vcnt) - vsub;
        else                       ctr_v = int'(in_vcnt) + FRAME_HEIGHT - vsub;
    end

    always_comb begin
        in_img    = (ctr_v < IMAGE_HEIGHT) && (ctr_h < IMAGE_WIDTH);
        at_origin = (ctr_v == 0) && (ctr_h == 0);
        wu_done   = (wu_q == WU_W'(LATENCY));
        // A newly sampled mode already governs the origin pixel itself.
        mode_eff  = at_origin ? pad_mode : mode_q;
        mode_d    = mode_eff;
        wu_d      = wu_done ? wu_q : wu_q + 1'b1;

        for (int v = 0; v < PATCH_HEIGHT; v++) begin
            rsel[v]  = tap_sel(ctr_v, v, CENTER_V, IMAGE_HEIGHT, mode_eff);
            rzero[v] = (mode_eff == 2'd1) && tap_out(ctr_v, v, CENTER_V, IMAGE_HEIGHT);
        end
        for (int h = 0; h < PATCH_WIDTH; h++) begin
            csel[h]  = tap_sel(ctr_h, h, CENTER_H, IMAGE_WIDTH, mode_eff);
            czero[h] = (mode_eff == 2'd1) && tap_out(ctr_h, h, CENTER_H, IMAGE_WIDTH);
        end

        out_patch_d = '0;
        for (int v = 0; v < PATCH_HEIGHT; v++) begin
            for (int h = 0; h < PATCH_WIDTH; h++) begin
                if (in_img && !rzero[v] && !czero[h]) begin
                    for (int i = 0; i < PATCH_HEIGHT; i++)
                        for (int j = 0; j < PATCH_WIDTH; j++)
                            if (rsel[v] == i && csel[h] == j)
                                out_patch_d[v][h] = win_q[i][j];
                end
            end
        end

        out_vcnt_d  = VW'(ctr_v);
        out_hcnt_d  = HW'(ctr_h);
        out_valid_d = wu_done && in_img;
    end

    // Output stage.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            out_patch_q <= '0;
            out_vcnt_q  <= '0;
            out_hcnt_q  <= '0;
            out_valid_q <= 1'b0;
            wu_q        <= '0;
            mode_q      <= 2'd0;
        end else begin
            out_patch_q <= out_patch_d;
            out_vcnt_q  <= out_vcnt_d;
            out_hcnt_q  <= out_hcnt_d;
            out_valid_q <= out_valid_d;
            wu_q        <= wu_d;
            mode_q      <= mode_d;
        end
    end

    assign out_patch = out_patch_q;
    assign out_vcnt  = out_vcnt_q;
    assign out_hcnt  = out_hcnt_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_patch_mc.sv
// -----------------------------------------------------------------------------
// tb_stream_patch_mc
//
// Directed bench for stream_patch_mc with a 2-channel 4x6 image in a 6x10
// frame and a centered 3x3 patch. The stream is continuous raster; pixel (v,h)
// carries v*16+h on channel 0 and its complement on channel 1.
// -----------------------------------------------------------------------------
module tb_stream_patch_mc;

    localparam int CH = 2;
    localparam int BW = 8;
    localparam int IH = 4;
    localparam int IW = 6;
    localparam int FH = 6;
    localparam int FW = 10;
    localparam int PH = 3;
    localparam int PW = 3;
    localparam int LAT = 13;

    logic                          clock;
    logic                          n_rst;
    logic [CH*BW-1:0]              in_pixel;
    logic [2:0]                    in_vcnt;
    logic [3:0]                    in_hcnt;
    logic [1:0]                    pad_mode;
    logic [0:PH-1][0:PW-1][CH*BW-1:0] out_patch;
    logic [2:0]                    out_vcnt;
    logic [3:0]                    out_hcnt;
    logic                          out_valid;

    int checks = 0;
    int errors = 0;
    int cur_v = 0, cur_h = 0;
    int smp_v = 0, smp_h = 0;
    logic early;
    logic found;

    stream_patch_mc #(
        .CHANNELS(CH), .BIT_WIDTH(BW),
        .IMAGE_HEIGHT(IH), .IMAGE_WIDTH(IW),
        .FRAME_HEIGHT(FH), .FRAME_WIDTH(FW),
        .PATCH_HEIGHT(PH), .PATCH_WIDTH(PW)
    ) dut (
        .clock(clock),
        .n_rst(n_rst),
        .in_pixel(in_pixel),
        .in_vcnt(in_vcnt),
        .in_hcnt(in_hcnt),
        .pad_mode(pad_mode),
        .out_patch(out_patch),
        .out_vcnt(out_vcnt),
        .out_hcnt(out_hcnt),
        .out_valid(out_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] pix(input int v, input int h);
        logic [7:0] b;
        b = 8'(v * 16 + h);
        return {~b, b};
    endfunction

    task automatic drive();
        in_vcnt  = 3'(cur_v);
        in_hcnt  = 4'(cur_h);
        in_pixel = pix(cur_v, cur_h);
    endtask

    // One clock: the DUT samples the current position, then the stream advances.
    task automatic tick();
        @(posedge clock);
        #1;
        smp_v = cur_v;
        smp_h = cur_h;
        if (cur_h == FW - 1) begin
            cur_h = 0;
            cur_v = (cur_v == FH - 1) ? 0 : cur_v + 1;
        end else begin
            cur_h = cur_h + 1;
        end
        drive();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Run until the output register shows center (tv,th); the input sampled on
    // that edge is LAT-1 raster positions ahead of the center.
    task automatic advance_out(input int tv, input int th);
        int t;
        t = (tv * FW + th + LAT - 1) % (FW * FH);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (smp_v * FW + smp_h == t) begin
                found = 1'b1;
                break;
            end
        end
        check("advance_out_reached", 32'(found), 32'd1);
        check("out_vcnt", 32'(out_vcnt), 32'(tv));
        check("out_hcnt", 32'(out_hcnt), 32'(th));
    endtask

    // Run until position (v,h) is being driven but not yet sampled.
    task automatic advance_in(input int v, input int h);
        found = (cur_v == v) && (cur_h == h);
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            found = (cur_v == v) && (cur_h == h);
        end
        check("advance_in_reached", 32'(found), 32'd1);
    endtask

    initial begin
        n_rst    = 1'b0;
        pad_mode = 2'd1;
        drive();
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_patch_zero", 32'(out_patch == '0), 32'd1);
        check("rst_vcnt", 32'(out_vcnt), 32'd0);
        check("rst_hcnt", 32'(out_hcnt), 32'd0);
        n_rst = 1'b1;

        // Frame 0 origin, then frame 1 origin in zero mode.
        advance_out(0, 0);
        advance_out(0, 0);
        check("zero_valid", 32'(out_valid), 32'd1);
        check("zero_00", 32'(out_patch[0][0]), 32'h0000);
        check("zero_02", 32'(out_patch[0][2]), 32'h0000);
        check("zero_20", 32'(out_patch[2][0]), 32'h0000);
        check("zero_11", 32'(out_patch[1][1]), 32'hFF00);
        check("zero_12", 32'(out_patch[1][2]), 32'hFE01);
        check("zero_21", 32'(out_patch[2][1]), 32'hEF10);
        check("zero_22", 32'(out_patch[2][2]), 32'hEE11);

        // Mid-frame switch to mirror: the rest of frame 1 keeps zero padding.
        advance_in(2, 0);
        pad_mode = 2'd3;
        advance_out(3, 5);
        check("sw_valid", 32'(out_valid), 32'd1);
        check("sw_11", 32'(out_patch[1][1]), 32'hCA35);
        check("sw_12", 32'(out_patch[1][2]), 32'h0000);
        check("sw_21", 32'(out_patch[2][1]), 32'h0000);
        check("sw_00", 32'(out_patch[0][0]), 32'hDB24);

        // Frame 2 in mirror mode.
        advance_out(0, 0);
        check("mir_org_00", 32'(out_patch[0][0]), 32'hEE11);
        check("mir_org_11", 32'(out_patch[1][1]), 32'hFF00);
        advance_out(3, 5);
        check("mir_valid", 32'(out_valid), 32'd1);
        check("mir_11", 32'(out_patch[1][1]), 32'hCA35);
        check("mir_12", 32'(out_patch[1][2]), 32'hCB34);
        check("mir_21", 32'(out_patch[2][1]), 32'hDA25);
        check("mir_22", 32'(out_patch[2][2]), 32'hDB24);
        check("mir_00", 32'(out_patch[0][0]), 32'hDB24);

        // Frame 3 in replicate mode.
        pad_mode = 2'd2;
        advance_out(0, 0);
        check("rep_valid", 32'(out_valid), 32'd1);
        check("rep_00", 32'(out_patch[0][0]), 32'hFF00);
        check("rep_02", 32'(out_patch[0][2]), 32'hFE01);
        check("rep_20", 32'(out_patch[2][0]), 32'hEF10);
        check("rep_22", 32'(out_patch[2][2]), 32'hEE11);

        // Blanking center.
        advance_out(4, 7);
        check("blank_valid", 32'(out_valid), 32'd0);
        check("blank_patch_zero", 32'(out_patch == '0), 32'd1);

        // Asynchronous reset in the middle of frame 4.
        advance_in(2, 3);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        n_rst = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_patch_zero", 32'(out_patch == '0), 32'd1);
        check("arst_vcnt", 32'(out_vcnt), 32'd0);
        check("arst_hcnt", 32'(out_hcnt), 32'd0);
        advance_in(4, 0);
        n_rst = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            tick();
            check("warmup_valid", 32'(out_valid), 32'd0);
        end
        early = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (smp_v == 1 && smp_h == 2) begin
                found = 1'b1;
                break;
            end
            if (out_valid) early = 1'b1;
        end
        check("rise_reached", 32'(found), 32'd1);
        check("no_early_valid", 32'(early), 32'd0);
        check("rise_valid", 32'(out_valid), 32'd1);
        check("rise_vcnt", 32'(out_vcnt), 32'd0);
        check("rise_hcnt", 32'(out_hcnt), 32'd0);
        check("rise_rep_00", 32'(out_patch[0][0]), 32'hFF00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
